i2c_reg_target: RTL

I2C target (responder) with a register-pointer front end, oversampled by the system clock. It decodes START, address and STOP conditions, then ACKs its own 7-bit chip_id. On writes it loads a register pointer and presents DATA_BYTES-wide words to a register-file port. On reads it serializes words fetched from that port. It sits on the same SDA/SCL pad wiring as the bus controller and serves as the far end of every master transaction issued in the design.

---
 rtl/i2c_reg_target.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_target.sv
// I2C target with a register-pointer front end, oversampled by clk_i.
// Write: START, addr+W, AddrBytes pointer bytes, then DataBytes-wide words.
// Read:  START, addr+R, words fetched from rd_data_i at the current pointer.
module i2c_reg_target #(
  parameter int unsigned AddrBytes    = 1,
  parameter int unsigned DataBytes    = 2,
  parameter int unsigned RegAddrWidth = 8 * AddrBytes
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    open_drain_i,
  input  logic [6:0]              chip_id_i,
  output logic [RegAddrWidth-1:0] reg_addr_o,
  output logic [8*DataBytes-1:0]  wr_data_o,
  output logic                    wr_en_o,
  input  logic [8*DataBytes-1:0]  rd_data_i,
  output logic                    rd_strobe_o,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic                    sda_i,
  output logic                    sda_o,
  output logic                    sda_oen_o,
  input  logic                    scl_i
);

  localparam int unsigned WordW = 8 * DataBytes;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
  } state_e;

  // [0],[1] synchronizer stages; [2] previous synchronized value for edge detection
  logic [2:0] scl_q, sda_q;

  state_e                  state_q, state_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              byte_cnt_q, byte_cnt_d;
  logic [7:0]              sh_q, sh_d;
  logic                    rw_q, rw_d;
  logic                    ack_q, ack_d;
  logic [RegAddrWidth-1:0] ptr_acc_q, ptr_acc_d;
  logic [WordW-1:0]        wacc_q, wacc_d;
  logic [WordW-1:0]        tx_q, tx_d;
  logic                    drive_q, drive_d;
  logic                    bit_q, bit_d;
  logic [RegAddrWidth-1:0] reg_addr_q, reg_addr_d;
  logic [WordW-1:0]        wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_strobe_q, rd_strobe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    inc_q, inc_d;

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [RegAddrWidth-1:0] ptr_next;
  logic [WordW-1:0]        word_next;

  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

  assign ptr_next  = RegAddrWidth'({ptr_acc_q, sh_q});
  assign word_next = WordW'({wacc_q, sh_q});

  // Pad synchronizers; reset to the idle-bus level so reset release sees no edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  // Protocol state and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      sh_q        <= '0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      ptr_acc_q   <= '0;
      wacc_q      <= '0;
      tx_q        <= '0;
      drive_q     <= 1'b0;
      bit_q       <= 1'b0;
      reg_addr_q  <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      inc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      sh_q        <= sh_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      ptr_acc_q   <= ptr_acc_d;
      wacc_q      <= wacc_d;
      tx_q        <= tx_d;
      drive_q     <= drive_d;
      bit_q       <= bit_d;
      reg_addr_q  <= reg_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_strobe_q <= rd_strobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      inc_q       <= inc_d;
    end
  end

  // Next-state: bus conditions override bit-level activity in every state
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    sh_d        = sh_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    ptr_acc_d   = ptr_acc_q;
    wacc_d      = wacc_q;
    tx_d        = tx_q;
    drive_d     = drive_q;
    bit_d       = bit_q;
    reg_addr_d  = inc_q ? reg_addr_q + RegAddrWidth'(1) : reg_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rd_strobe_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    inc_d       = 1'b0;

    if (!enable_i) begin
      state_d    = StIdle;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      drive_d    = 1'b0;
      busy_d     = 1'b0;
    end else if (start_det) begin
      state_d    = StAddr;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      drive_d    = 1'b0;
      busy_d     = 1'b0;
    end else if (stop_det) begin
      state_d    = StIdle;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      drive_d    = 1'b0;
      done_d     = busy_q;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            sh_d      = {sh_q[6:0], sda_q[1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            drive_d   = 1'b1;
            bit_d     = 1'b0;
            case (state_q)
              StAddr: begin
                if (sh_q[7:1] == chip_id_i) begin
                  busy_d  = 1'b1;
                  rw_d    = sh_q[0];
                  state_d = StAddrAck;
                end else begin
                  drive_d = 1'b0;
                  state_d = StIgnore;
                end
              end
              StPtr: begin
                ptr_acc_d = ptr_next;
                if (byte_cnt_q == 8'(AddrBytes - 1)) reg_addr_d = ptr_next;
                state_d = StPtrAck;
              end
              default: begin
                wacc_d  = word_next;
                state_d = StWdataAck;
              end
            endcase
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            if (rw_q) begin
              tx_d        = {rd_data_i[WordW-2:0], 1'b0};
              bit_d       = rd_data_i[WordW-1];
              drive_d     = 1'b1;
              rd_strobe_d = 1'b1;
              state_d     = StRdata;
            end else begin
              drive_d = 1'b0;
              state_d = StPtr;
            end
          end
        end
        StPtrAck: begin
          if (scl_fall) begin
            drive_d   = 1'b0;
            bit_cnt_d = '0;
            if (byte_cnt_q == 8'(AddrBytes - 1)) begin
              byte_cnt_d = '0;
              state_d    = StWdata;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
              state_d    = StPtr;
            end
          end
        end
        StWdataAck: begin
          if (scl_fall) begin
            drive_d   = 1'b0;
            bit_cnt_d = '0;
            state_d   = StWdata;
            if (byte_cnt_q == 8'(DataBytes - 1)) begin
              wr_data_d  = wacc_q;
              wr_en_d    = 1'b1;
              inc_d      = 1'b1;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              drive_d   = 1'b0;
              bit_cnt_d = '0;
              state_d   = StRdataAck;
            end else begin
              bit_d   = tx_q[WordW-1];
              tx_d    = {tx_q[WordW-2:0], 1'b0};
              drive_d = 1'b1;
            end
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            ack_d = sda_q[1];
            // Advance before the slot ends so the next fetch sees the new word
            if (!sda_q[1] && byte_cnt_q == 8'(DataBytes - 1)) begin
              reg_addr_d = reg_addr_q + RegAddrWidth'(1);
            end
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            if (ack_q) begin
              drive_d = 1'b0;
              state_d = StIgnore;
            end else if (byte_cnt_q == 8'(DataBytes - 1)) begin
              byte_cnt_d  = '0;
              tx_d        = {rd_data_i[WordW-2:0], 1'b0};
              bit_d       = rd_data_i[WordW-1];
              drive_d     = 1'b1;
              rd_strobe_d = 1'b1;
              state_d     = StRdata;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
              bit_d      = tx_q[WordW-1];
              tx_d       = {tx_q[WordW-2:0], 1'b0};
              drive_d    = 1'b1;
              state_d    = StRdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_addr_o  = reg_addr_q;
  assign wr_data_o   = wr_data_q;
  assign wr_en_o     = wr_en_q;
  assign rd_strobe_o = rd_strobe_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  // Open-drain only ever pulls low; push-pull drives the bit value while transmitting
  assign sda_o       = open_drain_i ? 1'b0 : (drive_q & bit_q);
  assign sda_oen_o   = drive_q & (open_drain_i ? ~bit_q : 1'b1);

endmodule
